// File: rtl/serial_adder.sv
// Bit-serial adder: latches a, b, cin on start and adds one bit pair per
// clock LSB-first. The result appears on sum/cout with a one-cycle done pulse.
// Ports: clk, rst_n (async, active-low), start, a, b, cin -> busy, done,
//   sum, cout, and ovf (signed overflow) when SERIAL_ADDER_OVF_EN is defined.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] sh_a, sh_a_nxt;
  logic [WIDTH-1:0] sh_b, sh_b_nxt;
  logic [WIDTH-1:0] sh_s, sh_s_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             carry, carry_nxt;
  logic             busy_nxt, done_nxt, cout_nxt;
  logic             s_bit, c_bit, last;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_nxt;
`endif

  // full-adder cell on the current LSB pair
  assign s_bit = sh_a[0] ^ sh_b[0] ^ carry;
  assign c_bit = (sh_a[0] & sh_b[0])
               | (carry & (sh_a[0] ^ sh_b[0]));
  assign last  = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sh_a_nxt  = sh_a;
    sh_b_nxt  = sh_b;
    sh_s_nxt  = sh_s;
    carry_nxt = carry;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    sum_nxt   = sum;
    cout_nxt  = cout;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_nxt   = ovf;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          sh_a_nxt  = a;
          sh_b_nxt  = b;
          sh_s_nxt  = '0;
          carry_nxt = cin;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        sh_a_nxt  = sh_a >> 1;
        sh_b_nxt  = sh_b >> 1;
        sh_s_nxt  = {s_bit, sh_s[WIDTH-1:1]};
        carry_nxt = c_bit;
        cnt_nxt   = cnt + CW'(1);
        if (last) begin
          sum_nxt   = {s_bit, sh_s[WIDTH-1:1]};
          cout_nxt  = c_bit;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
`ifdef SERIAL_ADDER_OVF_EN
          // carry into the MSB differs from carry out of it
          ovf_nxt   = carry ^ c_bit;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a  <= '0;
      sh_b  <= '0;
      sh_s  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      sh_a  <= sh_a_nxt;
      sh_b  <= sh_b_nxt;
      sh_s  <= sh_s_nxt;
      carry <= carry_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      sum   <= sum_nxt;
      cout  <= cout_nxt;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= ovf_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: WIDTH=8 directed/random scenarios and an
// exhaustive WIDTH=4 sweep against an arithmetic reference.
module tb_serial_adder;

  localparam int W  = 8;
  localparam int W4 = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  logic          start4 = 1'b0;
  logic [W4-1:0] a4 = '0, b4 = '0;
  logic          cin4 = 1'b0;
  logic          busy4, done4, cout4;
  logic [W4-1:0] sum4;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf, ovf4;
`endif

  int vectors = 0;
  int errors  = 0;
  int done_cnt4 = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf4),
`endif
    .sum(sum4), .cout(cout4)
  );

  always @(posedge clk)
    if (rst_n && done4) done_cnt4 <= done_cnt4 + 1;

  // reference: full-width integer sum split into {cout, sum}
  function automatic int ref_add(int x, int y, int c);
    return x + y + c;
  endfunction

  // reference: signed result outside the w-bit two's-complement range
  function automatic bit ref_ovf(int x, int y, int c, int w);
    int sx, sy, s;
    sx = (x >= (1 << (w - 1))) ? x - (1 << w) : x;
    sy = (y >= (1 << (w - 1))) ? y - (1 << w) : y;
    s  = sx + sy + c;
    return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
  endfunction

  task automatic launch(input int x, input int y, input int c);
    @(negedge clk);
    a = W'(x); b = W'(y); cin = c[0];
    start = 1'b1;
  endtask

  // counts cycles from acceptance until done (-1 on timeout)
  task automatic wait_done(input bit drop, output int cyc,
                           output int bcnt);
    cyc = 0; bcnt = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (drop && cyc == 1) start = 1'b0;
      if (busy) bcnt++;
    end while (!done && cyc < 4 * W);
    if (!done) cyc = -1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, done, cout, sum} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b cout=%b sum=%h want 0",
               busy, done, cout, sum);
    end
`ifdef SERIAL_ADDER_OVF_EN
    vectors++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got %b want 0", ovf);
    end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    int tab [4][3] = '{'{8'hFF, 8'h01, 0}, '{8'h7F, 8'h01, 0},
                       '{8'hA5, 8'h5A, 1}, '{8'h80, 8'h80, 0}};
    int x, y, c, r, cyc, bcnt;
    for (int i = 0; i < 24; i++) begin
      if (i < 4) begin
        x = tab[i][0]; y = tab[i][1]; c = tab[i][2];
      end else begin
        x = int'($urandom_range(255));
        y = int'($urandom_range(255));
        c = int'($urandom_range(1));
      end
      r = ref_add(x, y, c);
      launch(x, y, c);
      wait_done(1'b1, cyc, bcnt);
      vectors++;
      if (cyc != W + 1 || bcnt != W || busy !== 1'b0) begin
        errors++;
        $display("FAIL add_timing got cyc=%0d busy_cycles=%0d busy=%b want %0d/%0d/0",
                 cyc, bcnt, busy, W + 1, W);
      end
      vectors++;
      if ({cout, sum} !== (W + 1)'(r)) begin
        errors++;
        $display("FAIL add_result %h+%h+%0d got %b_%h want %h",
                 x, y, c, cout, sum, (W + 1)'(r));
      end
`ifdef SERIAL_ADDER_OVF_EN
      vectors++;
      if (ovf !== ref_ovf(x, y, c, W)) begin
        errors++;
        $display("FAIL add_ovf %h+%h+%0d got %b want %b",
                 x, y, c, ovf, ref_ovf(x, y, c, W));
      end
`endif
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || {cout, sum} !== (W + 1)'(r)) begin
        errors++;
        $display("FAIL add_hold got done=%b %b_%h want 0 %h",
                 done, cout, sum, (W + 1)'(r));
      end
    end
  endtask

  task automatic test_ignore_busy;
    int pulses = 0;
    int cyc = 0;
    launch(8'h03, 8'h04, 0);
    while (cyc < 4 * W && pulses == 0) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 3) begin
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
      end
      if (done) pulses++;
    end
    start = 1'b0;
    vectors++;
    if (cyc != W + 1 || {cout, sum} !== 9'h007) begin
      errors++;
      $display("FAIL ignore_busy got cyc=%0d %b_%h want %0d 0_07",
               cyc, cout, sum, W + 1);
    end
    repeat (2 * W) begin
      @(negedge clk);
      if (done) pulses++;
    end
    vectors++;
    if (pulses != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy_pulses got %0d busy=%b want 1 0",
               pulses, busy);
    end
  endtask

  task automatic test_reset_midrun;
    int pulses = 0;
    int cyc, bcnt;
    launch(8'h10, 8'h20, 0);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, cout, sum} !== '0) begin
      errors++;
      $display("FAIL midrun_reset got busy=%b done=%b %b_%h want all 0",
               busy, done, cout, sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * W) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midrun_no_done got %0d active cycles want 0", pulses);
    end
    launch(8'h01, 8'h01, 0);
    wait_done(1'b1, cyc, bcnt);
    vectors++;
    if (cyc != W + 1 || {cout, sum} !== 9'h002) begin
      errors++;
      $display("FAIL midrun_restart got cyc=%0d %b_%h want %0d 0_02",
               cyc, cout, sum, W + 1);
    end
  endtask

  task automatic test_back_to_back;
    int x, y, cyc, bcnt, r;
    x = int'($urandom_range(255));
    y = int'($urandom_range(255));
    r = ref_add(x, y, 0);
    launch(x, y, 0);
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0;
    cyc = 1;
    while (!done && cyc < 4 * W) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc != W + 1 || {cout, sum} !== (W + 1)'(r)) begin
      errors++;
      $display("FAIL b2b_first got cyc=%0d %b_%h want %0d %h",
               cyc, cout, sum, W + 1, (W + 1)'(r));
    end
    wait_done(1'b1, cyc, bcnt);
    vectors++;
    if (cyc != W + 1 || bcnt != W || {cout, sum} !== 9'h033) begin
      errors++;
      $display("FAIL b2b_second got cyc=%0d busy=%0d %b_%h want %0d %0d 0_33",
               cyc, bcnt, cout, sum, W + 1, W);
    end
    @(negedge clk);
  endtask

  task automatic test_exhaustive_w4;
    int cyc, r;
    int base;
    base = done_cnt4;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      a4 = W4'(i & 15); b4 = W4'((i >> 4) & 15); cin4 = i[8];
      start4 = 1'b1;
      r = ref_add(i & 15, (i >> 4) & 15, i >> 8);
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        start4 = 1'b0;
      end while (!done4 && cyc < 4 * W4);
      vectors++;
      if (cyc != W4 + 1 || {cout4, sum4} !== (W4 + 1)'(r)) begin
        errors++;
        $display("FAIL w4_sum %h+%h+%0d got cyc=%0d %b_%h want %0d %h",
                 a4, b4, cin4, cyc, cout4, sum4, W4 + 1, (W4 + 1)'(r));
      end
`ifdef SERIAL_ADDER_OVF_EN
      vectors++;
      if (ovf4 !== ref_ovf(i & 15, (i >> 4) & 15, i >> 8, W4)) begin
        errors++;
        $display("FAIL w4_ovf %h+%h+%0d got %b", a4, b4, cin4, ovf4);
      end
`endif
    end
    @(negedge clk);
    vectors++;
    if (done_cnt4 - base != 512) begin
      errors++;
      $display("FAIL w4_done_count got %0d want 512", done_cnt4 - base);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_ignore_busy;
    test_reset_midrun;
    test_back_to_back;
    test_exhaustive_w4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
